gray_decoder_pipe: RTL and testbench

Two-stage pipelined Gray-to-binary decoder with valid/ready handshakes. It sits directly downstream of the 8-bit binary-to-Gray encoder and consumes Gray words that have crossed a clock or mechanical boundary (position encoders, counters). It recovers the binary value and checks that each accepted Gray word differs from the previous one in at most one bit. It keeps a saturating count of violations.

---
 rtl/gray_decoder_pipe.sv | 140 ++++++++++++++
 tb/tb_gray_decoder_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_decoder_pipe.sv
// Two-stage pipelined Gray-to-binary decoder with valid/ready handshakes,
// single-bit step checking against the previous accepted word and a saturating violation count.
module gray_decoder_pipe #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CNT_W        = 8,
  parameter bit          ALLOW_REPEAT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] binario_out,
  output logic             step_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             clear_err
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned DW   = $clog2(WIDTH + 1);

  logic             s1_valid;
  logic [HALF-1:0]  s1_hi_bin;
  logic [HALF-1:0]  s1_lo_gray;
  logic             s1_err;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_bin;
  logic             s2_err;

  logic             hist_valid;
  logic [WIDTH-1:0] prev_gray;

  logic             s2_load;
  logic             s1_load;
  logic             in_xfer;
  logic             out_xfer;

  logic [HALF-1:0]  hi_bin_c;
  logic [HALF-1:0]  lo_bin_c;
  logic [WIDTH-1:0] diff_c;
  logic [DW-1:0]    dist_c;
  logic             step_flag_c;

  // Stage advance; in_ready never looks at in_valid
  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign in_xfer  = in_valid && s1_load;
  assign out_xfer = s2_valid && out_ready;

  assign out_valid   = s2_valid;
  assign binario_out = s2_bin;
  assign step_err    = s2_err;

  // Upper half of the decode, straight from the incoming Gray word
  always_comb begin
    hi_bin_c = '0;
    hi_bin_c[HALF-1] = gray_in[WIDTH-1];
    for (int i = int'(HALF) - 2; i >= 0; i--) begin
      hi_bin_c[i] = hi_bin_c[i+1] ^ gray_in[HALF+i];
    end
  end

  // Lower half, continuing the prefix XOR from the stored b[HALF]
  always_comb begin
    lo_bin_c = '0;
    lo_bin_c[HALF-1] = s1_hi_bin[0] ^ s1_lo_gray[HALF-1];
    for (int i = int'(HALF) - 2; i >= 0; i--) begin
      lo_bin_c[i] = lo_bin_c[i+1] ^ s1_lo_gray[i];
    end
  end

  // Hamming distance to the previous accepted word; a clear in the same cycle leaves the word unchecked
  always_comb begin
    diff_c = gray_in ^ prev_gray;
    dist_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dist_c = dist_c + DW'(diff_c[i]);
    end
    step_flag_c = hist_valid && !clear_err &&
                  ((dist_c > DW'(1)) || ((dist_c == '0) && !ALLOW_REPEAT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_hi_bin  <= '0;
      s1_lo_gray <= '0;
      s1_err     <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_hi_bin  <= hi_bin_c;
        s1_lo_gray <= gray_in[HALF-1:0];
        s1_err     <= step_flag_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_bin   <= '0;
      s2_err   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_bin <= {s1_hi_bin, lo_bin_c};
        s2_err <= s1_err;
      end
    end
  end

  // History: an accepted word always becomes the new reference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_valid <= 1'b0;
      prev_gray  <= '0;
    end else if (in_xfer) begin
      hist_valid <= 1'b1;
      prev_gray  <= gray_in;
    end else if (clear_err) begin
      hist_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clear_err) begin
      err_count <= '0;
    end else if (out_xfer && s2_err && (err_count != '1)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_decoder_pipe.sv
// Bench for gray_decoder_pipe: two instances (repeat legal / repeat illegal) share stimulus
// and are compared every cycle against a FIFO-style reference model.
module tb_gray_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] gray_in;
  logic       out_ready;
  logic       clear_err;

  logic       in_ready_a, out_valid_a, step_err_a;
  logic [7:0] binario_out_a, err_count_a;
  logic       in_ready_b, out_valid_b, step_err_b;
  logic [7:0] binario_out_b, err_count_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] bin;
    bit         fa;
    bit         fb;
    int         avail;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         cnt_a = 0;
  int         cnt_b = 0;
  bit         hist = 1'b0;
  logic [7:0] prev = 8'h00;

  gray_decoder_pipe #(.WIDTH(8), .CNT_W(8), .ALLOW_REPEAT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .gray_in(gray_in), .out_valid(out_valid_a), .out_ready(out_ready),
    .binario_out(binario_out_a), .step_err(step_err_a), .err_count(err_count_a),
    .clear_err(clear_err)
  );

  gray_decoder_pipe #(.WIDTH(8), .CNT_W(8), .ALLOW_REPEAT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .gray_in(gray_in), .out_valid(out_valid_b), .out_ready(out_ready),
    .binario_out(binario_out_b), .step_err(step_err_b), .err_count(err_count_b),
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  // Binary value is the XOR of all right shifts of the Gray word
  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < 8; k++) b = b ^ (g >> k);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    clear_err = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_out_valid_a", 32'(out_valid_a), 32'd0);
    chk("rst_out_valid_b", 32'(out_valid_b), 32'd0);
    chk("rst_in_ready_a", 32'(in_ready_a), 32'd1);
    chk("rst_in_ready_b", 32'(in_ready_b), 32'd1);
    chk("rst_err_count_a", 32'(err_count_a), 32'd0);
    chk("rst_err_count_b", 32'(err_count_b), 32'd0);
    chk("rst_binario_a", 32'(binario_out_a), 32'd0);
    chk("rst_step_err_a", 32'(step_err_a), 32'd0);
    q.delete();
    cnt_a = 0;
    cnt_b = 0;
    hist  = 1'b0;
    prev  = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: check registered outputs, drive inputs, check in_ready, advance the model
  task automatic cycle(input bit v, input logic [7:0] g, input bit ordy, input bit clr);
    bit   ov, ir, ix, ox;
    int   d;
    exp_t e;
    @(negedge clk);
    ov = (q.size() > 0) && (q[0].avail <= cyc);
    chk("out_valid_a", 32'(out_valid_a), 32'(ov));
    chk("out_valid_b", 32'(out_valid_b), 32'(ov));
    if (ov) begin
      chk("binario_out_a", 32'(binario_out_a), 32'(q[0].bin));
      chk("binario_out_b", 32'(binario_out_b), 32'(q[0].bin));
      chk("step_err_a", 32'(step_err_a), 32'(q[0].fa));
      chk("step_err_b", 32'(step_err_b), 32'(q[0].fb));
    end
    chk("err_count_a", 32'(err_count_a), 32'(cnt_a));
    chk("err_count_b", 32'(err_count_b), 32'(cnt_b));
    in_valid  = v;
    gray_in   = g;
    out_ready = ordy;
    clear_err = clr;
    #1;
    ir = (q.size() < 2) || ordy;
    chk("in_ready_a", 32'(in_ready_a), 32'(ir));
    chk("in_ready_b", 32'(in_ready_b), 32'(ir));
    ix = v && ir;
    ox = ov && ordy;
    if (ox) begin
      if (q[0].fa && cnt_a < 255) cnt_a++;
      if (q[0].fb && cnt_b < 255) cnt_b++;
      void'(q.pop_front());
    end
    if (clr) begin
      cnt_a = 0;
      cnt_b = 0;
    end
    if (ix) begin
      d       = $countones(g ^ prev);
      e.bin   = g2b(g);
      e.fa    = hist && !clr && (d > 1);
      e.fb    = hist && !clr && (d != 1);
      e.avail = cyc + 2;
      q.push_back(e);
      prev = g;
      hist = 1'b1;
    end else if (clr) begin
      hist = 1'b0;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] last_g;
    logic [7:0] rg;
    int         sel;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    gray_in   = 8'h00;
    out_ready = 1'b0;
    clear_err = 1'b0;

    do_reset();
    cycle(1'b1, 8'h07, 1'b1, 1'b0);
    idle(3);

    // Counting sequence from a fresh history
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b1, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h01, 1'b1, 1'b0);
    cycle(1'b1, 8'h03, 1'b1, 1'b0);
    cycle(1'b1, 8'h02, 1'b1, 1'b0);
    cycle(1'b1, 8'h06, 1'b1, 1'b0);
    idle(3);

    // Illegal jump then a repeat
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b1, 8'h01, 1'b1, 1'b0);
    cycle(1'b1, 8'h07, 1'b1, 1'b0);
    cycle(1'b1, 8'h07, 1'b1, 1'b0);
    idle(3);

    // Reset with words in flight, then the first word must be unchecked
    cycle(1'b1, 8'h3c, 1'b0, 1'b0);
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 8'h07, 1'b1, 1'b0);
    idle(3);

    // Backpressure: three offered, two taken, then pass-through on release
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    cycle(1'b1, 8'h30, 1'b0, 1'b0);
    cycle(1'b1, 8'h70, 1'b0, 1'b0);
    cycle(1'b1, 8'h70, 1'b0, 1'b0);
    cycle(1'b1, 8'h70, 1'b1, 1'b0);
    idle(4);

    // Saturation, clear coinciding with a flagged delivery, then unchecked distance-3 word
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 259; i++) cycle(1'b1, (i % 2 == 1) ? 8'h03 : 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b1, 8'h07, 1'b1, 1'b0);
    idle(3);

    // Extremes
    cycle(1'b1, 8'h80, 1'b1, 1'b0);
    cycle(1'b1, 8'hc0, 1'b1, 1'b0);
    cycle(1'b1, 8'hff, 1'b1, 1'b0);
    idle(3);

    // Random traffic: mostly legal single-bit steps, some repeats and jumps
    last_g = 8'hff;
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       rg = last_g ^ (8'h01 << $urandom_range(0, 7));
      else if (sel == 7) rg = last_g;
      else               rg = 8'($urandom);
      cycle(1'($urandom_range(0, 3) != 0), rg, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 40) == 0));
      if (in_valid && in_ready_a) last_g = rg;
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
